// File: rtl/div_uart_seq.sv
// div_uart_seq: frame sequencer between a UART byte interface and an iterative divider.
//
// A request frame is four big-endian bytes: A[15:8], A[7:0], B[15:8], B[7:0]. The frame is
// handed to the divider (A / B). The result is then sent back big-endian, one byte per
// transmitter handshake. A zero divisor skips the divider, returns an all-ones quotient and
// sets the sticky err_div0 flag. A partial frame is discarded after RX_TIMEOUT idle cycles.
//
// Build option: define DIV_REMAINDER_EN to also transmit the remainder after the quotient.
// A zero divisor then sends FF FF A[15:8] A[7:0]. Without it, only the quotient is sent.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rx_ready, rx_data   received byte strobe and data
//   div_start           one-cycle start pulse; div_a/div_b hold the operands until div_done
//   div_done            one-cycle completion pulse; div_q/div_r are valid with it
//   tx_start, tx_data   one-cycle transmit pulse; tx_data holds the byte until the next pulse
//   tx_busy             transmitter busy, rises no later than the cycle after tx_start
//   busy                high from the accepted 4th request byte until the last byte is sent
//   err_div0            sticky divide-by-zero flag, cleared by the next frame's first byte
module div_uart_seq #(
    parameter int unsigned BIT_MAX    = 16,
    parameter int unsigned RX_TIMEOUT = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_ready,
    input  logic [7:0]         rx_data,
    output logic               div_start,
    output logic [BIT_MAX-1:0] div_a,
    output logic [BIT_MAX-1:0] div_b,
    input  logic               div_done,
    input  logic [BIT_MAX-1:0] div_q,
    input  logic [BIT_MAX-1:0] div_r,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic               busy,
    output logic               err_div0
);

    localparam int unsigned OP_BYTES    = BIT_MAX / 8;
    localparam int unsigned FRAME_BYTES = 2 * OP_BYTES;
    localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + 1);
`ifdef DIV_REMAINDER_EN
    localparam int unsigned TX_BYTES    = 2 * OP_BYTES;
`else
    localparam int unsigned TX_BYTES    = OP_BYTES;
`endif
    localparam int unsigned TX_W        = TX_BYTES * 8;
    localparam int unsigned TXC_W       = $clog2(TX_BYTES + 1);
    localparam int unsigned TO_W        = $clog2(RX_TIMEOUT + 1);

    localparam logic [2:0] StRx      = 3'd0;
    localparam logic [2:0] StCheck   = 3'd1;
    localparam logic [2:0] StDivWait = 3'd2;
    localparam logic [2:0] StTxLoad  = 3'd3;
    localparam logic [2:0] StTxArm   = 3'd4;
    localparam logic [2:0] StTxWait  = 3'd5;

    logic [2:0]           state_q,   state_d;
    logic [2*BIT_MAX-1:0] frame_q,   frame_d;    // {A, B}, filled by shifting bytes in
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [TO_W-1:0]      to_q,      to_d;
    logic [TX_W-1:0]      tx_sr_q,   tx_sr_d;    // result bytes, MSB byte goes out first
    logic [TXC_W-1:0]     tx_left_q, tx_left_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 err_q,     err_d;
    logic                 b_zero;

`ifndef DIV_REMAINDER_EN
    logic unused_div_r;
    assign unused_div_r = ^div_r;
`endif

    assign div_a     = frame_q[2*BIT_MAX-1 -: BIT_MAX];
    assign div_b     = frame_q[BIT_MAX-1:0];
    assign b_zero    = (div_b == '0);
    assign div_start = (state_q == StCheck) && !b_zero;
    assign tx_start  = (state_q == StTxLoad) && !tx_busy;
    // The new byte must be visible in the tx_start cycle itself, then it is held.
    assign tx_data   = tx_start ? tx_sr_q[TX_W-1 -: 8] : tx_data_q;
    assign busy      = (state_q != StRx);
    assign err_div0  = err_q;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        tx_sr_d   = tx_sr_q;
        tx_left_d = tx_left_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;

        case (state_q)
            StRx: begin
                if (rx_ready) begin
                    // A byte always beats a timeout expiring in the same cycle.
                    frame_d = {frame_q[2*BIT_MAX-9:0], rx_data};
                    to_d    = '0;
                    if (cnt_q == '0) begin
                        err_d = 1'b0;
                    end
                    if (cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = StCheck;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    if (to_q == TO_W'(RX_TIMEOUT - 1)) begin
                        cnt_d   = '0;
                        to_d    = '0;
                        frame_d = '0;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (b_zero) begin
                    err_d     = 1'b1;
`ifdef DIV_REMAINDER_EN
                    tx_sr_d   = {{BIT_MAX{1'b1}}, div_a};
`else
                    tx_sr_d   = {BIT_MAX{1'b1}};
`endif
                    tx_left_d = TXC_W'(TX_BYTES);
                    state_d   = StTxLoad;
                end else begin
                    state_d = StDivWait;
                end
            end
            StDivWait: begin
                if (div_done) begin
`ifdef DIV_REMAINDER_EN
                    tx_sr_d   = {div_q, div_r};
`else
                    tx_sr_d   = div_q;
`endif
                    tx_left_d = TXC_W'(TX_BYTES);
                    state_d   = StTxLoad;
                end
            end
            StTxLoad: begin
                if (!tx_busy) begin
                    tx_data_d = tx_sr_q[TX_W-1 -: 8];
                    tx_sr_d   = tx_sr_q << 8;
                    tx_left_d = tx_left_q - 1'b1;
                    state_d   = StTxArm;
                end
            end
            // Transmitter may only raise busy one cycle after tx_start; don't look yet.
            StTxArm: begin
                state_d = StTxWait;
            end
            StTxWait: begin
                if (!tx_busy) begin
                    state_d = (tx_left_q == '0) ? StRx : StTxLoad;
                end
            end
            default: begin
                state_d = StRx;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StRx;
            frame_q   <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            tx_sr_q   <= '0;
            tx_left_q <= '0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            tx_sr_q   <= tx_sr_d;
            tx_left_q <= tx_left_d;
            tx_data_q <= tx_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_div_uart_seq.sv
// Testbench for div_uart_seq: directed and random request frames checked against a
// behavioural reference (plain / and % on the operands), with bus models for the divider
// and the UART transmitter.
module tb_div_uart_seq;

    localparam int unsigned RX_TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        div_start;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic        div_done = 1'b0;
    logic [15:0] div_q = 16'h0;
    logic [15:0] div_r = 16'h0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        err_div0;

    div_uart_seq #(
        .BIT_MAX    (16),
        .RX_TIMEOUT (RX_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_q     (div_q),
        .div_r     (div_r),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .err_div0  (err_div0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_tx_start  = 0;
    int n_div_start = 0;
    int tx_viol     = 0;
    int div_viol    = 0;
    int tx_hold     = 2;
    int div_lat     = 16;
    int busy_rem    = 0;
    int div_rem     = 0;
    bit pend_rise   = 1'b0;
    logic [7:0]  tx_q[$];
    logic [7:0]  last_tx = 8'h00;
    logic [15:0] cap_a = 16'h0;
    logic [15:0] cap_b = 16'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Divider model: answers div_start after div_lat cycles with a one-cycle div_done.
    always @(negedge clk) begin
        div_done = 1'b0;
        if (div_rem > 0) begin
            div_rem--;
            if (div_rem == 0) begin
                if (busy && (div_a !== cap_a || div_b !== cap_b)) div_viol++;
                div_q    = (cap_b != 0) ? cap_a / cap_b : 16'hFFFF;
                div_r    = (cap_b != 0) ? cap_a % cap_b : cap_a;
                div_done = 1'b1;
            end
        end
        if (div_start === 1'b1) begin
            n_div_start++;
            if (div_rem > 0) div_viol++;
            cap_a   = div_a;
            cap_b   = div_b;
            div_rem = div_lat;
        end
    end

    // Transmitter model: records bytes, holds tx_busy for tx_hold cycles after each start.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (tx_busy) tx_viol++;
            tx_q.push_back(tx_data);
            last_tx = tx_data;
            n_tx_start++;
            if (tx_hold > 0) begin
                busy_rem  = tx_hold;
                pend_rise = 1'b1;
            end
        end else if (tx_busy && busy && tx_data !== last_tx) begin
            tx_viol++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (pend_rise) begin
            pend_rise = 1'b0;
            tx_busy   = 1'b1;
        end else if (busy_rem > 0) begin
            busy_rem--;
            if (busy_rem == 0) tx_busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input int gap,
                             input bit inject);
        logic [7:0]  exp_q[$];
        logic [15:0] q;
        logic [15:0] r;
        int          div_base;
        int          k;
        bit          done;
        bit          inj_tx;

        if (b == 0) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        exp_q.push_back(q[15:8]);
        exp_q.push_back(q[7:0]);
`ifdef DIV_REMAINDER_EN
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
`endif
        tx_q.delete();
        div_base = n_div_start;

        send_byte(a[15:8]);
        check("err_clear_first_byte", err_div0, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(a[7:0]);
        repeat (gap) @(negedge clk);
        send_byte(b[15:8]);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(b[7:0]);

        check("busy_after_4th", busy, 1);
        check("div_start_latency", div_start, (b != 0));
        if (b != 0) begin
            check("div_a", div_a, a);
            check("div_b", div_b, b);
        end

        done   = 1'b0;
        inj_tx = 1'b0;
        for (k = 1; k <= 6000; k++) begin
            @(negedge clk);
            rx_ready = 1'b0;
            if (k == 1) begin
                check("err_div0_set", err_div0, (b == 0));
                if (b == 0) check("div0_tx_latency", tx_start, 1);
            end
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            if (inject && k == 3) begin
                rx_data  = 8'($urandom);
                rx_ready = 1'b1;
            end else if (inject && !inj_tx && tx_q.size() >= 1 && tx_busy) begin
                inj_tx   = 1'b1;
                rx_data  = 8'($urandom);
                rx_ready = 1'b1;
            end
        end
        rx_ready = 1'b0;
        check("frame_completes", done, 1);
        check("tx_byte_count", tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            check("tx_byte", {i[7:0], tx_q[i]}, {i[7:0], exp_q[i]});
        end
        check("div_start_count", n_div_start - div_base, (b != 0) ? 1 : 0);
        check("err_div0_sticky", err_div0, (b == 0));
        check("tx_handshake_viol", tx_viol, 0);
        check("div_handshake_viol", div_viol, 0);
    endtask

    initial begin
        int base;
        logic [15:0] ra;
        logic [15:0] rb;

        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, div_start, tx_start, err_div0, tx_data, div_a, div_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Normal divide, then divide by zero, then a clean frame clears the flag.
        run_frame(16'd100, 16'd7, 1, 1'b0);
        run_frame(16'h1234, 16'h0000, 1, 1'b0);
        run_frame(16'd500, 16'd3, 1, 1'b0);

        // Partial frame discarded by timeout; the next full frame is the only result.
        base = n_tx_start;
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (RX_TO + 4) @(negedge clk);
        check("timeout_silent", n_tx_start - base, 0);
        check("timeout_not_busy", busy, 0);
        run_frame(16'h0050, 16'h0005, 1, 1'b0);

        // A gap just under the timeout must keep the partial frame.
        run_frame(16'd1000, 16'd33, RX_TO - 10, 1'b0);

        // Back-pressure.
        tx_hold = 200;
        run_frame(16'd100, 16'd7, 1, 1'b0);
        run_frame(16'hABCD, 16'h0000, 1, 1'b0);
        tx_hold = 2;

        // Bytes arriving while busy are dropped.
        run_frame(16'd100, 16'd7, 1, 1'b1);
        run_frame(16'd65535, 16'd255, 1, 1'b0);

        // Reset during DIV_WAIT.
        div_lat = 40;
        send_byte(8'h03);
        send_byte(8'hE8);
        send_byte(8'h00);
        send_byte(8'h0A);
        repeat (5) @(negedge clk);
        check("rst_div_busy_before", busy, 1);
        base = n_tx_start;
        rst  = 1'b1;
        #1;
        check("rst_div_outputs", {busy, div_start, tx_start, err_div0, tx_data, div_a, div_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rst_div_no_tx", n_tx_start - base, 0);
        check("rst_div_idle", busy, 0);

        // Reset during TX_WAIT.
        div_lat = 4;
        tx_hold = 30;
        base    = n_tx_start;
        send_byte(8'h00);
        send_byte(8'h64);
        send_byte(8'h00);
        send_byte(8'h07);
        for (int i = 0; i < 200 && n_tx_start == base; i++) @(negedge clk);
        check("rst_tx_first_start", n_tx_start - base, 1);
        repeat (5) @(negedge clk);
        check("rst_tx_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_tx_outputs", {busy, div_start, tx_start, err_div0, tx_data, div_a, div_b}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rst_tx_no_stray", n_tx_start - base, 1);
        tx_hold = 2;
        div_lat = 16;
        run_frame(16'd100, 16'd7, 1, 1'b0);

        // Random frames.
        for (int n = 0; n < 20; n++) begin
            div_lat = $urandom_range(1, 20);
            tx_hold = $urandom_range(0, 4);
            ra      = 16'($urandom);
            rb      = ($urandom_range(0, 4) == 0) ? 16'h0000 :
                      ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) :
                                                     16'($urandom_range(1, 65535));
            run_frame(ra, rb, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
